// File: rtl/jdec_pkg.sv
// Shared constants and types for the JPEG decode-side inverse quantizer.
package jdec_pkg;

    localparam int unsigned QW_DEF          = 11;
    localparam int unsigned DW_DEF          = 15;
    localparam int unsigned M_BITS_DEF      = 13;
    localparam int unsigned BLOCKS_PER_MCU  = 6;
    localparam int unsigned PAIRS_PER_BLOCK = 32;

    typedef enum logic [1:0] {
        Y  = 2'd0,
        CB = 2'd1,
        CR = 2'd2
    } chroma_t;

    // 4:2:0 MCU layout: four Y blocks, then Cb, then Cr.
    function automatic chroma_t blk_to_chroma(input logic [2:0] blk);
        chroma_t c;
        if (blk == 3'd4) begin
            c = CB;
        end else if (blk == 3'd5) begin
            c = CR;
        end else begin
            c = Y;
        end
        return c;
    endfunction

endpackage

// File: rtl/dequant_tables.sv
// Dequant factor store: even/odd zigzag banks, one write port, both banks read together.
module dequant_tables
    import jdec_pkg::*;
#(
    parameter int unsigned M_BITS = M_BITS_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [6:0]        i_wa,
    input  logic [M_BITS-1:0] i_wd,
    input  logic              i_re,
    input  logic [5:0]        i_ra,
    output logic [M_BITS-1:0] o_rd_even,
    output logic [M_BITS-1:0] o_rd_odd
);

    logic [M_BITS-1:0] r_mem_even [64];
    logic [M_BITS-1:0] r_mem_odd  [64];
    logic [5:0]        w_waddr;

    assign w_waddr = {i_wa[6], i_wa[5:1]};

    // Read and write share the edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (i_we && !i_wa[0]) begin
            r_mem_even[w_waddr] <= i_wd;
        end
        if (i_we && i_wa[0]) begin
            r_mem_odd[w_waddr] <= i_wd;
        end
        if (i_re) begin
            o_rd_even <= r_mem_even[i_ra];
            o_rd_odd  <= r_mem_odd[i_ra];
        end
    end

endmodule

// File: rtl/dequant.sv
// JPEG inverse quantizer: 3-stage pair pipeline with 4:2:0 MCU tracking.
// Define DEQUANT_SAT_EN to clamp outputs and expose a sticky sat_flag.
module dequant
    import jdec_pkg::*;
#(
    parameter int unsigned QW            = QW_DEF,
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned M_BITS        = M_BITS_DEF,
    parameter int unsigned F_SHIFT       = 0,
    parameter int unsigned SENSOR_X_SIZE = 1280,
    parameter int unsigned SENSOR_Y_SIZE = 720
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef DEQUANT_SAT_EN
    output logic                              sat_flag,
`endif
    input  logic [1:0][QW-1:0]                q,
    input  logic                              q_valid,
    output logic                              q_hold,
    input  logic [4:0]                        q_cnt,
    output logic [1:0][DW-1:0]                d,
    output logic                              d_valid,
    input  logic                              d_hold,
    output logic [4:0]                        d_cnt,
    output logic [1:0]                        d_chroma,
    output logic                              d_last_mcu,
    input  logic [$clog2(SENSOR_X_SIZE)-1:0]  x_size_m1,
    input  logic [$clog2(SENSOR_Y_SIZE)-1:0]  y_size_m1,
    input  logic                              tbl_we,
    input  logic [6:0]                        tbl_wa,
    input  logic [M_BITS-1:0]                 tbl_wd
);

    localparam int unsigned XW  = $clog2(SENSOR_X_SIZE);
    localparam int unsigned YW  = $clog2(SENSOR_Y_SIZE);
    localparam int unsigned XMW = XW - 4;
    localparam int unsigned YMW = YW - 4;
    localparam int unsigned PW  = QW + M_BITS + 1;
    localparam int unsigned SW  = PW + 1;

    logic           w_en;
    logic           w_xfer;
    logic           w_blk_end;
    logic           w_mcu_end;
    logic           w_last;
    logic [XMW-1:0] w_x_max;
    logic [YMW-1:0] w_y_max;

    logic [2:0]     r_blk;
    logic [XMW-1:0] r_x_mcu;
    logic [YMW-1:0] r_y_mcu;

    logic                 r0_valid;
    logic [1:0][QW-1:0]   r0_q;
    logic [4:0]           r0_cnt;
    chroma_t              r0_chroma;
    logic                 r0_last;

    logic                 r1_valid;
    logic signed [PW-1:0] r1_prod [2];
    logic [4:0]           r1_cnt;
    chroma_t              r1_chroma;
    logic                 r1_last;

    logic [M_BITS-1:0]    w_fac  [2];
    logic signed [PW-1:0] w_prod [2];
    logic [DW-1:0]        w_d    [2];

    assign w_en      = ~d_hold;
    assign q_hold    = d_hold;
    assign w_xfer    = q_valid & w_en;
    assign w_blk_end = w_xfer && (q_cnt == 5'(PAIRS_PER_BLOCK - 1));
    assign w_mcu_end = w_blk_end && (r_blk == 3'(BLOCKS_PER_MCU - 1));
    assign w_x_max   = XMW'(x_size_m1 >> 4);
    assign w_y_max   = YMW'(y_size_m1 >> 4);
    assign w_last    = (r_blk == 3'(BLOCKS_PER_MCU - 1)) && (r_x_mcu == w_x_max)
                       && (r_y_mcu == w_y_max);

    // Block and MCU position; x runs fastest, both wrap to 0 after the final MCU.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk   <= 3'd0;
            r_x_mcu <= '0;
            r_y_mcu <= '0;
        end else begin
            if (w_blk_end) begin
                r_blk <= (r_blk == 3'(BLOCKS_PER_MCU - 1)) ? 3'd0 : r_blk + 3'd1;
            end
            if (w_mcu_end) begin
                if (r_x_mcu == w_x_max) begin
                    r_x_mcu <= '0;
                    r_y_mcu <= (r_y_mcu == w_y_max) ? '0 : r_y_mcu + 1'b1;
                end else begin
                    r_x_mcu <= r_x_mcu + 1'b1;
                end
            end
        end
    end

    dequant_tables #(
        .M_BITS(M_BITS)
    ) u_tables (
        .clk      (clk),
        .i_we     (tbl_we),
        .i_wa     (tbl_wa),
        .i_wd     (tbl_wd),
        .i_re     (w_en),
        .i_ra     ({r_blk[2], q_cnt}),
        .o_rd_even(w_fac[0]),
        .o_rd_odd (w_fac[1])
    );

`ifdef DEQUANT_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - 1;
    logic w_sat [2];
`endif

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic signed [SW-1:0] w_ext;
        logic signed [SW-1:0] w_shf;

        // Factor is unsigned: zero-extend before the signed multiply.
        assign w_prod[i] = PW'($signed(r0_q[i])) * PW'($signed({1'b0, w_fac[i]}));
        assign w_ext     = SW'(r1_prod[i]);

        if (F_SHIFT > 0) begin : g_rnd
            logic signed [SW-1:0] w_rnd;
            assign w_rnd = w_ext + (SW'(1) << (F_SHIFT - 1));
            assign w_shf = w_rnd >>> F_SHIFT;
        end else begin : g_nornd
            assign w_shf = w_ext;
        end

`ifdef DEQUANT_SAT_EN
        assign w_sat[i] = (w_shf > SAT_MAX) || (w_shf < SAT_MIN);
        assign w_d[i]   = (w_shf > SAT_MAX) ? DW'(SAT_MAX) :
                          (w_shf < SAT_MIN) ? DW'(SAT_MIN) : DW'(w_shf);
`else
        assign w_d[i]   = DW'(w_shf);
`endif
    end

    // All stages share one enable so a hold freezes the whole pipe in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_valid   <= 1'b0;
            r0_q       <= '0;
            r0_cnt     <= 5'd0;
            r0_chroma  <= Y;
            r0_last    <= 1'b0;
            r1_valid   <= 1'b0;
            r1_prod[0] <= '0;
            r1_prod[1] <= '0;
            r1_cnt     <= 5'd0;
            r1_chroma  <= Y;
            r1_last    <= 1'b0;
            d_valid    <= 1'b0;
            d          <= '0;
            d_cnt      <= 5'd0;
            d_chroma   <= 2'd0;
            d_last_mcu <= 1'b0;
        end else if (w_en) begin
            r0_valid   <= q_valid;
            r0_q       <= q;
            r0_cnt     <= q_cnt;
            r0_chroma  <= blk_to_chroma(r_blk);
            r0_last    <= w_last;
            r1_valid   <= r0_valid;
            r1_prod[0] <= w_prod[0];
            r1_prod[1] <= w_prod[1];
            r1_cnt     <= r0_cnt;
            r1_chroma  <= r0_chroma;
            r1_last    <= r0_last;
            d_valid    <= r1_valid;
            d[0]       <= w_d[0];
            d[1]       <= w_d[1];
            d_cnt      <= r1_cnt;
            d_chroma   <= r1_chroma;
            d_last_mcu <= r1_last;
        end
    end

`ifdef DEQUANT_SAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (w_en && r1_valid && (w_sat[0] || w_sat[1])) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule
